mux_scan_sequencer: RTL and testbench

//  Drives the 3-bit select bus of the 8x1 mux tree (three levels of 2x1 Multiplexer)
//  and samples its 1-bit output for every channel in turn. Each scan assembles one

---
 rtl/mux_scan_sequencer.sv | 114 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the mux-tree select bus through every channel,
// waits SETTLE cycles per channel, samples the tree output and publishes one
// CHANNELS-bit frame per scan behind a start/busy/done handshake.
module mux_scan_sequencer #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mux_out,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                done,
    output logic [CHANNELS-1:0] frame
);

    // Counter only has to reach SETTLE-1; keep at least one bit for SETTLE==1.
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              state_q,  state_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [CHANNELS-1:0] frame_q,  frame_d;
    logic [CHANNELS-1:0] shadow_q, shadow_d;

    // State and datapath registers; rst wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frame_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state and next-output logic; done is a single-cycle pulse by default-low.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frame_d  = frame_q;
        shadow_d = shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                shadow_d[sel_q] = mux_out;
                if (sel_q == SEL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                frame_d = shadow_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                sel_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel   = sel_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: models the 8x1 mux tree as an indexed vector
// and scoreboards expected frames and done cycles against the done pulses.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start3;
    logic [7:0] mux_in, mux_in3;
    logic       mux_out, mux_out3;
    logic [2:0] sel, sel3;
    logic       busy, busy3, done, done3;
    logic [7:0] frame, frame3;

    typedef struct {
        logic [7:0] frame;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Mux tree model: output is the input selected by the current select bus.
    assign mux_out  = mux_in[sel];
    assign mux_out3 = mux_in3[sel3];

    mux_scan_sequencer #(.CHANNELS(8), .SEL_W(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mux_out(mux_out),
        .sel(sel), .busy(busy), .done(done), .frame(frame)
    );

    mux_scan_sequencer #(.CHANNELS(8), .SEL_W(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mux_out(mux_out3),
        .sel(sel3), .busy(busy3), .done(done3), .frame(frame3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] f, input int c);
        exp_t e;
        e.frame = f;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start3 = 1'b0; mux_in = 8'h00; mux_in3 = 8'h00;
        tick();
        tick();
        checks++; if (sel !== 3'd0)     begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (frame !== 8'h00)  begin errors++; $display("FAIL reset_frame got %h exp 00", frame); end
        checks++; if (busy3 !== 1'b0)   begin errors++; $display("FAIL reset_busy3 got %b exp 0", busy3); end
        checks++; if (frame3 !== 8'h00) begin errors++; $display("FAIL reset_frame3 got %h exp 00", frame3); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_scan();
        exp_t       e;
        logic [2:0] exp_sel;
        mux_in = 8'hA6;
        push_exp(8'hA6, 17);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 17; t++) begin
            if (t > 0) tick();
            exp_sel = (t >= 17) ? 3'd0 : ((t / 2) > 7 ? 3'd7 : 3'(t / 2));
            checks++; if (sel !== exp_sel) begin errors++; $display("FAIL single_sel t=%0d got %0d exp %0d", t, sel, exp_sel); end
            checks++; if (busy !== (t < 17)) begin errors++; $display("FAIL single_busy t=%0d got %b exp %b", t, busy, (t < 17)); end
            checks++; if (done !== (t == 17)) begin errors++; $display("FAIL single_done t=%0d got %b exp %b", t, done, (t == 17)); end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++; $display("FAIL single_unexpected_done t=%0d got done exp none", t);
                end else begin
                    e = sb.pop_front();
                    checks++; if (frame !== e.frame) begin errors++; $display("FAIL single_frame got %h exp %h", frame, e.frame); end
                    checks++; if (t != e.cyc) begin errors++; $display("FAIL single_cycle got %0d exp %0d", t, e.cyc); end
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_missing_done got %0d pending exp 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_start_busy();
        exp_t e;
        int   ndone = 0;
        mux_in = 8'h5C;
        push_exp(8'h5C, 17);
        start = 1'b1;
        tick();
        for (int t = 1; t <= 40; t++) begin
            start = (t == 5 || t == 17);
            tick();
            if (t <= 16) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_held t=%0d got %b exp 1", t, busy); end
            end
            if (done === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL busy_extra_done t=%0d got done exp none", t);
                end else begin
                    e = sb.pop_front();
                    checks++; if (frame !== e.frame) begin errors++; $display("FAIL busy_frame got %h exp %h", frame, e.frame); end
                    checks++; if (t != e.cyc) begin errors++; $display("FAIL busy_cycle got %0d exp %0d", t, e.cyc); end
                end
            end
        end
        start = 1'b0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
        sb.delete();
    endtask

    task automatic test_continuous();
        exp_t       e;
        logic [7:0] pat [3];
        int         n = 1;
        int         ndone = 0;
        pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'h55;
        mux_in = pat[0];
        push_exp(pat[0], 17);
        start = 1'b1;
        tick();
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL cont_extra_done t=%0d got done exp none", t);
                end else begin
                    e = sb.pop_front();
                    checks++; if (frame !== e.frame) begin errors++; $display("FAIL cont_frame t=%0d got %h exp %h", t, frame, e.frame); end
                    checks++; if (t != e.cyc) begin errors++; $display("FAIL cont_cycle got %0d exp %0d", t, e.cyc); end
                end
                if (n < 3) begin
                    mux_in = pat[n];
                    push_exp(pat[n], 17 + 18 * n);
                    n++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (ndone != 3) begin errors++; $display("FAIL cont_done_count got %0d exp 3", ndone); end
        sb.delete();
    endtask

    task automatic test_settle();
        exp_t       e;
        logic [7:0] pat = 8'h93;
        int         ndone = 0;
        mux_in3 = ~pat;
        push_exp(pat, 33);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            mux_in3 = ((t % 4) == 0 && t <= 32) ? pat : ~pat;
            tick();
            checks++; if (busy3 !== (t <= 32)) begin errors++; $display("FAIL settle_busy t=%0d got %b exp %b", t, busy3, (t <= 32)); end
            if (done3 === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL settle_extra_done t=%0d got done exp none", t);
                end else begin
                    e = sb.pop_front();
                    checks++; if (frame3 !== e.frame) begin errors++; $display("FAIL settle_frame got %h exp %h", frame3, e.frame); end
                    checks++; if (t != e.cyc) begin errors++; $display("FAIL settle_cycle got %0d exp %0d", t, e.cyc); end
                end
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL settle_done_count got %0d exp 1", ndone); end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   ndone = 0;
        mux_in = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            if (t == 7) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL mid_done got %b exp 0", done); end
        checks++; if (frame !== 8'h00) begin errors++; $display("FAIL mid_frame got %h exp 00", frame); end
        checks++; if (sel !== 3'd0)    begin errors++; $display("FAIL mid_sel got %0d exp 0", sel); end
        for (int t = 0; t < 25; t++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL mid_stray_done got %0d exp 0", ndone); end
        mux_in = 8'h39;
        push_exp(8'h39, 17);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL mid_extra_done t=%0d got done exp none", t);
                end else begin
                    e = sb.pop_front();
                    checks++; if (frame !== e.frame) begin errors++; $display("FAIL mid_frame_after got %h exp %h", frame, e.frame); end
                    checks++; if (t != e.cyc) begin errors++; $display("FAIL mid_cycle got %0d exp %0d", t, e.cyc); end
                end
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL mid_done_count got %0d exp 1", ndone); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_single_scan();
        tick();
        test_start_busy();
        tick();
        test_continuous();
        tick();
        test_settle();
        tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
